// File: rtl/sobel_pkg.sv
// Shared types, Sobel coefficients and arithmetic helpers for the 3x3 Sobel
// streaming stage.
package sobel_pkg;

  typedef logic [7:0]         pixel_t;
  typedef logic signed [10:0] grad_t;
  typedef logic [10:0]        mag_t;

  // Column/row weights of the separable Sobel kernel: [1 2 1].
  localparam grad_t SOBEL_EDGE_W   = 11'sd1;
  localparam grad_t SOBEL_CENTER_W = 11'sd2;

  // Weighted sum of three pixels along one kernel edge (max 1020).
  function automatic grad_t col_sum(pixel_t a, pixel_t b, pixel_t c);
    grad_t ea;
    grad_t eb;
    grad_t ec;
    ea = grad_t'({3'b000, a});
    eb = grad_t'({3'b000, b});
    ec = grad_t'({3'b000, c});
    return ea * SOBEL_EDGE_W + eb * SOBEL_CENTER_W + ec * SOBEL_EDGE_W;
  endfunction

  // Absolute value of a gradient; |g| <= 1020 so -1024 never occurs.
  function automatic mag_t abs11(grad_t g);
    grad_t n;
    n = -g;
    return g[10] ? mag_t'(n) : mag_t'(g);
  endfunction

endpackage

// File: rtl/sobel3x3_window_if.sv
// Actor-style token ports of the Sobel stage, input and output sides.
// Handshake: an input token moves on a cycle where In1_SEND and In1_ACK are
// both high; an output token moves on a cycle where Out1_SEND is high, which
// only happens while Out1_RDY is high. Out1_DATA is stable while a token is
// waiting on Out1_RDY.
interface sobel3x3_window_if;
  logic [7:0]  In1_DATA;
  logic        In1_SEND;
  logic [15:0] In1_COUNT;
  logic        In1_ACK;
  logic [7:0]  Out1_DATA;
  logic        Out1_SEND;
  logic        Out1_RDY;
  logic        Out1_ACK;
  logic [15:0] Out1_COUNT;

  modport master (
    output In1_DATA, In1_SEND, In1_COUNT, Out1_RDY, Out1_ACK,
    input  In1_ACK, Out1_DATA, Out1_SEND, Out1_COUNT
  );

  modport slave (
    input  In1_DATA, In1_SEND, In1_COUNT, Out1_RDY, Out1_ACK,
    output In1_ACK, Out1_DATA, Out1_SEND, Out1_COUNT
  );
endinterface

// File: rtl/sobel_line_buffer.sv
// Two-line pixel store addressed by column. A write pushes the previous
// line's pixel down one line; reads return the contents before the write.
// Contents are intentionally not reset.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH = 512,
  localparam int AW = $clog2(IMG_WIDTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  pixel_t        wdata,
  output pixel_t        top,
  output pixel_t        mid
);

  pixel_t lb0 [IMG_WIDTH];
  pixel_t lb1 [IMG_WIDTH];

  assign top = lb1[addr];
  assign mid = lb0[addr];

  // Shift the column down one line and store the new pixel.
  always_ff @(posedge clk) begin
    if (we) begin
      lb1[addr] <= lb0[addr];
      lb0[addr] <= wdata;
    end
  end

endmodule

// File: rtl/sobel3x3_window.sv
// 3x3 Sobel gradient-magnitude stage: position counters, 3x3 window,
// gradient and magnitude pipeline, and whole-pipeline stall on Out1_RDY.
// Build option: SOBEL_SATURATE_EN selects saturation to 255 instead of
// divide-by-8 output scaling.
module sobel3x3_window
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input logic CLK,
  input logic RESET,
  sobel3x3_window_if.slave bus
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  pixel_t        win [3][3];
  pixel_t        tap_top;
  pixel_t        tap_mid;
  grad_t         gx_q;
  grad_t         gy_q;
  mag_t          mag;
  pixel_t        out_d;
  pixel_t        out_q;
  logic          v1;
  logic          v2;
  logic          v3;
  logic          advance;
  logic          accept;
  logic          unused_inputs;

  assign advance = !v3 || bus.Out1_RDY;
  assign accept  = bus.In1_SEND && advance && !RESET;

  assign bus.In1_ACK    = accept;
  assign bus.Out1_SEND  = v3 && bus.Out1_RDY;
  assign bus.Out1_DATA  = out_q;
  assign bus.Out1_COUNT = 16'd1;

  assign unused_inputs = ^{bus.In1_COUNT, bus.Out1_ACK};

  sobel_line_buffer #(.IMG_WIDTH(IMG_WIDTH)) u_lines (
    .clk   (CLK),
    .we    (accept),
    .addr  (col),
    .wdata (bus.In1_DATA),
    .top   (tap_top),
    .mid   (tap_mid)
  );

  // Raster position of the next accepted pixel; frames run back-to-back.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == CW'(IMG_WIDTH - 1)) begin
        col <= '0;
        row <= (row == RW'(IMG_HEIGHT - 1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Stage 1: shift the 3x3 window; valid only once rows/cols 0..2 are in.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      v1 <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else if (advance) begin
      v1 <= accept && (row >= RW'(2)) && (col >= CW'(2));
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= tap_top;
        win[1][2] <= tap_mid;
        win[2][2] <= bus.In1_DATA;
      end
    end
  end

  // Stage 2: horizontal and vertical Sobel gradients.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      gx_q <= '0;
      gy_q <= '0;
      v2   <= 1'b0;
    end else if (advance) begin
      gx_q <= col_sum(win[0][2], win[1][2], win[2][2])
            - col_sum(win[0][0], win[1][0], win[2][0]);
      gy_q <= col_sum(win[2][0], win[2][1], win[2][2])
            - col_sum(win[0][0], win[0][1], win[0][2]);
      v2   <= v1;
    end
  end

  assign mag = abs11(gx_q) + abs11(gy_q);

`ifdef SOBEL_SATURATE_EN
  assign out_d = (mag > mag_t'(255)) ? 8'hFF : mag[7:0];
`else
  logic unused_mag_lsb;
  assign unused_mag_lsb = ^mag[2:0];
  assign out_d = mag[10:3];
`endif

  // Stage 3: scaled magnitude, held while the output token waits.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_q <= '0;
      v3    <= 1'b0;
    end else if (advance) begin
      out_q <= out_d;
      v3    <= v2;
    end
  end

endmodule
